// File: rtl/result_serializer.sv
// Buffers 2x2 result matrices from the MMU (one active, one pending) and streams
// each as 8 bytes, high byte first, over a valid/ready byte stream.
module result_serializer #(
  parameter int DATA_W  = 16,
  parameter int OUT_W   = 8,
  parameter int N_ELEMS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] c00,
  input  logic [DATA_W-1:0] c01,
  input  logic [DATA_W-1:0] c10,
  input  logic [DATA_W-1:0] c11,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              overflow
);

  localparam int N_BYTES = 2 * N_ELEMS;
  localparam int IDX_W   = $clog2(N_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);

  typedef enum logic {IDLE, STREAM} state_t;
  typedef logic [N_ELEMS-1:0][DATA_W-1:0] frame_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  frame_t             active_q, active_d;
  frame_t             shadow_q, shadow_d;
  logic               shadow_vld_q, shadow_vld_d;
  logic               ovf_q, ovf_d;

  frame_t             in_frame;
  logic               xfer;
  logic               last_xfer;
  logic               drop;
  logic [DATA_W-1:0]  cur_elem;
  logic [OUT_W-1:0]   cur_byte;

  // Element 0 is c00 so that byte index / 2 selects the element directly.
  assign in_frame  = {c11, c10, c01, c00};
  assign xfer      = out_valid & out_ready;
  assign last_xfer = xfer & (idx_q == LAST_IDX);

  assign cur_elem  = active_q[idx_q[IDX_W-1:1]];
  assign cur_byte  = idx_q[0] ? cur_elem[OUT_W-1:0] : cur_elem[DATA_W-1:OUT_W];

  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid & (idx_q == LAST_IDX);
  assign out_data  = out_valid ? cur_byte : '0;
  assign busy      = out_valid | shadow_vld_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    drop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (res_valid) begin
          active_d = in_frame;
          idx_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (last_xfer) begin
          idx_d = '0;
          // A pending frame takes priority; a coincident new frame then refills the shadow.
          if (shadow_vld_q) begin
            active_d     = shadow_q;
            shadow_vld_d = res_valid;
            if (res_valid) shadow_d = in_frame;
          end else if (res_valid) begin
            active_d = in_frame;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (xfer) idx_d = idx_q + 1'b1;
          if (res_valid) begin
            if (shadow_vld_q) begin
              drop = 1'b1;
            end else begin
              shadow_d     = in_frame;
              shadow_vld_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop in the same cycle as a clear still leaves the flag set.
    ovf_d = drop | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Self-checking bench for result_serializer: a queue-of-frames model tracks what
// the byte stream must show each cycle, plus directed scenarios with literal checks.
module tb_result_serializer;

  logic        clk = 1'b0;
  logic        rst, res_valid, out_ready, ovf_clr;
  logic [15:0] c00, c01, c10, c11;
  logic [7:0]  out_data;
  logic        out_valid, out_last, busy, overflow;

  always #5 clk = ~clk;

  result_serializer #(.DATA_W(16), .OUT_W(8), .N_ELEMS(4)) dut (
    .clk(clk), .rst(rst), .res_valid(res_valid),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .out_ready(out_ready), .ovf_clr(ovf_clr),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;

  // Model: frames waiting or in flight (front = being sent), byte position in the front frame.
  logic [63:0] mq[$];
  int          bidx = 0;
  logic        movf = 1'b0;
  bit          check_en = 1'b0;
  bit          drop_m;
  logic        exp_v, exp_l, exp_b;
  logic [7:0]  exp_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [63:0] f, input int i);
    return f[63 - 8*i -: 8];
  endfunction

  // Model update on the same edge the DUT samples its inputs.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      bidx = 0;
      movf = 1'b0;
    end else begin
      drop_m = 1'b0;
      if (mq.size() > 0 && out_ready) begin
        if (bidx == 7) begin
          void'(mq.pop_front());
          bidx = 0;
        end else begin
          bidx++;
        end
      end
      if (res_valid) begin
        if (mq.size() < 2) mq.push_back({c00, c01, c10, c11});
        else drop_m = 1'b1;
      end
      if (drop_m) movf = 1'b1;
      else if (ovf_clr) movf = 1'b0;
    end
  end

  // Compare process: outputs depend only on DUT state, so the falling edge is stable.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      exp_v = (mq.size() > 0);
      exp_b = exp_v;
      exp_l = exp_v && (bidx == 7);
      exp_d = exp_v ? byte_of(mq[0], bidx) : 8'h00;
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
      chk("out_last",  {63'd0, out_last},  {63'd0, exp_l});
      chk("busy",      {63'd0, busy},      {63'd0, exp_b});
      chk("overflow",  {63'd0, overflow},  {63'd0, movf});
      if (exp_v) chk("out_data", {56'd0, out_data}, {56'd0, exp_d});
    end
  end

  task automatic set_frame(input logic [63:0] f);
    {c00, c01, c10, c11} = f;
  endtask

  logic [7:0] exp1 [8] = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'h00};
  int n_xfer;

  initial begin
    rst = 1'b1; res_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    set_frame(64'd0);
    repeat (2) @(negedge clk);
    chk("reset_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_busy",  {63'd0, busy},      64'd0);
    chk("reset_ovf",   {63'd0, overflow},  64'd0);
    chk("reset_data",  {56'd0, out_data},  64'd0);
    rst = 1'b0;
    check_en = 1'b1;

    // 1: single frame, ready held high, byte0 one cycle after the pulse.
    set_frame(64'h1234_ABCD_0001_FF00); res_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); res_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_byte", {56'd0, out_data}, {56'd0, exp1[i]});
      chk("t1_last", {63'd0, out_last}, (i == 7) ? 64'd1 : 64'd0);
      @(negedge clk);
    end
    chk("t1_idle", {63'd0, out_valid}, 64'd0);

    // 2: same frame, ready toggling; count transfers.
    res_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); res_valid = 1'b0;
    n_xfer = 0;
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3 == 0);
      if (out_valid && out_ready) begin
        chk("t2_byte", {56'd0, out_data}, {56'd0, exp1[n_xfer % 8]});
        n_xfer++;
      end
      @(negedge clk);
    end
    chk("t2_count", 64'(n_xfer), 64'd8);

    // 4: three pulses during a stall -> third dropped, flag sticky until cleared.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_frame({16'(i), 16'hA5A5, 16'h5A5A, 16'(i + 100)}); res_valid = 1'b1;
      @(negedge clk); res_valid = 1'b0;
      @(negedge clk);
    end
    chk("t4_ovf", {63'd0, overflow}, 64'd1);
    out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4_ovf_sticky", {63'd0, overflow}, 64'd1);
    ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
    chk("t4_ovf_clr", {63'd0, overflow}, 64'd0);

    // 5: pulse coincident with last-byte transfer while shadow full.
    set_frame(64'h1111_2222_3333_4444); res_valid = 1'b1;
    @(negedge clk); set_frame(64'h5555_6666_7777_8888);
    @(negedge clk); res_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("t5_last", {63'd0, out_last}, 64'd1);
    set_frame(64'h9999_AAAA_BBBB_CCCC); res_valid = 1'b1;
    @(negedge clk); res_valid = 1'b0;
    chk("t5_shadow_next", {56'd0, out_data}, 64'h55);
    repeat (16) @(negedge clk);
    chk("t5_ovf", {63'd0, overflow}, 64'd0);
    repeat (2) @(negedge clk);

    // 6: reset mid-frame with shadow full, then clean restart.
    set_frame(64'hDEAD_BEEF_CAFE_F00D); res_valid = 1'b1;
    @(negedge clk); set_frame(64'h0102_0304_0506_0708);
    @(negedge clk); res_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_valid", {63'd0, out_valid}, 64'd0);
    chk("t6_busy",  {63'd0, busy},      64'd0);
    chk("t6_last",  {63'd0, out_last},  64'd0);
    set_frame(64'hC0DE_0000_0000_0000); res_valid = 1'b1;
    @(negedge clk); res_valid = 1'b0;
    chk("t6_restart", {56'd0, out_data}, 64'hC0);

    // Random phase against the model.
    for (int i = 0; i < 4000; i++) begin
      res_valid = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      ovf_clr   = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 599) == 0);
      set_frame({$urandom, $urandom});
      @(negedge clk);
    end
    res_valid = 1'b0; rst = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
